// File: rtl/shared_add_arb.sv
// N-channel round-robin arbiter in front of one W+2-bit adder; op=1 reuses the
// adder on a second pass to form a+b+b. Results leave tagged with their channel.
module shared_add_arb #(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int CW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N-1:0]     in_op,
  input  logic [N*W-1:0]   in_a,
  input  logic [N*W-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W+1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  output logic [15:0]      done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [W+1:0]      acc_q, acc_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic              op_q, op_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [15:0]       done_q, done_d;

  logic [N-1:0][W-1:0] a_vec, b_vec;
  logic              gnt_hit;
  logic [CW-1:0]     gnt_idx, cand;
  logic [N-1:0]      rdy;
  logic [W+1:0]      add_x, add_y, sum;

  assign a_vec = in_a;
  assign b_vec = in_b;

  // Scan from the farthest candidate back toward ptr so the nearest valid wins.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N-1; k >= 0; k--) begin
      cand = CW'((int'(ptr_q) + k) % N);
      if (in_valid[cand]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // The only adder; EXEC2 feeds the first-pass sum back in place of a.
  assign add_x = (state_q == EXEC2) ? acc_q : {2'b00, a_q};
  assign add_y = {2'b00, b_q};
  assign sum   = add_x + add_y;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ch_d    = ch_q;
    done_d  = done_q;
    rdy     = '0;
    case (state_q)
      IDLE: begin
        if (gnt_hit) begin
          rdy[gnt_idx] = 1'b1;
          a_d     = a_vec[gnt_idx];
          b_d     = b_vec[gnt_idx];
          op_d    = in_op[gnt_idx];
          ch_d    = gnt_idx;
          ptr_d   = CW'((int'(gnt_idx) + 1) % N);
          state_d = EXEC1;
        end
      end
      EXEC1: begin
        acc_d   = sum;
        state_d = op_q ? EXEC2 : HOLD;
      end
      EXEC2: begin
        acc_d   = sum;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          done_d  = (done_q == 16'hFFFF) ? done_q : done_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // No request may be accepted while reset is held.
  assign in_ready  = rst_n ? rdy : '0;
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign out_ch    = ch_q;
  assign done_cnt  = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      ch_q    <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_shared_add_arb.sv
// Directed bench for shared_add_arb: expected results are queued at issue time
// and a negedge monitor pops them on every output handshake.
module tb_shared_add_arb;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in_valid, in_ready, in_op;
  logic [N*W-1:0]   in_a, in_b;
  logic             out_valid, out_ready;
  logic [W+1:0]     out_data;
  logic [CW-1:0]    out_ch;
  logic [15:0]      done_cnt;

  typedef struct { logic [W+1:0] d; logic [CW-1:0] ch; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  shared_add_arb #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_op[c]        = op;
    in_a[c*W +: W]  = a;
    in_b[c*W +: W]  = b;
    in_valid[c]     = 1'b1;
  endtask

  task automatic push(input logic [W+1:0] d, input logic [CW-1:0] ch);
    exp_t e;
    e.d  = d;
    e.ch = ch;
    exp_q.push_back(e);
  endtask

  // Returns at once if a grant is already showing, else waits on negedges.
  task automatic wait_grant(output logic [N-1:0] r);
    r = in_ready;
    for (int i = 0; i < 50 && r == '0; i++) begin
      @(negedge clk);
      r = in_ready;
    end
    if (r == '0) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_outv(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) return;
    end
    chk("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    chk("in_ready_onehot0", 32'($onehot0(in_ready)), 1);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got data %0d ch %0d, required no output", out_data, out_ch);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e.d));
        chk("out_ch",   32'(out_ch),   32'(mon_e.ch));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    int lat, last;
    int seq [6] = '{0, 1, 2, 3, 0, 1};

    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = '0; in_op = '0; in_a = '0; in_b = '0;
    for (int c = 0; c < N; c++) set_ch(c, 1'b0, W'(10*(c+1)), W'(c+1));

    // Reset with every channel requesting
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_done_cnt", 32'(done_cnt), 0);

    // Round-robin: ch0..3 then 0,1, one result every 3 cycles
    for (int k = 0; k < 6; k++) push(10'(11*(seq[k]+1)), CW'(seq[k]));
    last = 0;
    for (int k = 0; k < 6; k++) begin
      wait_grant(r);
      chk("rr_grant", 32'(r), 32'(1 << seq[k]));
      if (k > 0) chk("rr_spacing", cyc - last, 3);
      last = cyc;
      @(posedge clk); #1;
      if (k >= 2) in_valid[seq[k]] = 1'b0;
    end
    wait_drain();
    chk("rr_done_cnt", 32'(done_cnt), 6);

    // Single add on ch2: 200+100
    @(posedge clk); #1;
    set_ch(2, 1'b0, 8'd200, 8'd100);
    push(10'd300, 2'd2);
    wait_grant(r);
    chk("single_grant", 32'(r), 32'b0100);
    @(posedge clk); #1;
    in_valid = '0;
    wait_outv(lat);
    chk("single_latency", lat, 2);
    wait_drain();
    chk("single_done_cnt", 32'(done_cnt), 7);

    // Chained add on ch1: 255+255+255
    @(posedge clk); #1;
    set_ch(1, 1'b1, 8'd255, 8'd255);
    push(10'd765, 2'd1);
    wait_grant(r);
    chk("chain_grant", 32'(r), 32'b0010);
    @(posedge clk); #1;
    in_valid = '0;
    wait_outv(lat);
    chk("chain_latency", lat, 3);
    wait_drain();
    chk("chain_done_cnt", 32'(done_cnt), 8);

    // Backpressure: ptr=2 so ch3 wins over ch0, then held 5+ cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_ch(0, 1'b0, 8'd1, 8'd2);
    set_ch(3, 1'b0, 8'd5, 8'd6);
    push(10'd11, 2'd3);
    push(10'd3, 2'd0);
    wait_grant(r);
    chk("bp_grant", 32'(r), 32'b1000);
    @(posedge clk); #1;
    in_valid[3] = 1'b0;
    wait_outv(lat);
    chk("bp_latency", lat, 2);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data", 32'(out_data), 11);
      chk("bp_out_ch", 32'(out_ch), 3);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_done_cnt", 32'(done_cnt), 8);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_grant(r);
    chk("bp_next_grant", 32'(r), 32'b0001);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_drain();
    chk("bp_done_cnt_after", 32'(done_cnt), 10);

    // Reset during EXEC2 of a chained op on ch3: result discarded
    @(posedge clk); #1;
    set_ch(3, 1'b1, 8'd7, 8'd9);
    wait_grant(r);
    chk("mid_grant", 32'(r), 32'b1000);
    @(posedge clk); #1;
    in_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_ch(0, 1'b0, 8'd1, 8'd2);
    set_ch(2, 1'b0, 8'd200, 8'd100);
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_done_cnt", 32'(done_cnt), 0);
    push(10'd3, 2'd0);
    push(10'd300, 2'd2);
    wait_grant(r);
    chk("mid_post_grant", 32'(r), 32'b0001);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_grant(r);
    chk("mid_second_grant", 32'(r), 32'b0100);
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    wait_drain();
    chk("mid_done_cnt_after", 32'(done_cnt), 2);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
